// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: sends bytes to a 4-bit HD44780-style LCD as two timed nibble strobes (high nibble first).
// Optional macro LCD_INIT_SEQ_EN adds the power-up wait and the 0x3,0x3,0x3,0x2 init nibbles before IDLE.
module lcd_nibble_writer #(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int GAP_CYC       = 2000,
    parameter int LONG_GAP_CYC  = 82000,
    parameter int INIT_WAIT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       e,
    output logic       sf_e,
    output logic       rs,
    output logic       rw,
    output logic [3:0] lcd_nib
);

    // A zero count would otherwise mean "never leave the state", so it is promoted to one clock.
    localparam int S_EFF = (SETUP_CYC     < 1) ? 1 : SETUP_CYC;
    localparam int P_EFF = (PULSE_CYC     < 1) ? 1 : PULSE_CYC;
    localparam int H_EFF = (HOLD_CYC      < 1) ? 1 : HOLD_CYC;
    localparam int G_EFF = (GAP_CYC       < 1) ? 1 : GAP_CYC;
    localparam int L_EFF = (LONG_GAP_CYC  < 1) ? 1 : LONG_GAP_CYC;
    localparam int I_EFF = (INIT_WAIT_CYC < 1) ? 1 : INIT_WAIT_CYC;

    localparam int MAX_A   = (S_EFF > P_EFF) ? S_EFF : P_EFF;
    localparam int MAX_B   = (H_EFF > G_EFF) ? H_EFF : G_EFF;
    localparam int MAX_C   = (L_EFF > I_EFF) ? L_EFF : I_EFF;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t ONE      = cnt_t'(1);
    localparam cnt_t SETUP_LD = cnt_t'(S_EFF);
    localparam cnt_t PULSE_LD = cnt_t'(P_EFF);
    localparam cnt_t HOLD_LD  = cnt_t'(H_EFF);
    localparam cnt_t GAP_LD   = cnt_t'(G_EFF);
    localparam cnt_t LONG_LD  = cnt_t'(L_EFF);
`ifdef LCD_INIT_SEQ_EN
    localparam cnt_t INIT_LD  = cnt_t'(I_EFF);
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP_HI,
        ST_PULSE_HI,
        ST_HOLD_HI,
        ST_SETUP_LO,
        ST_PULSE_LO,
        ST_HOLD_LO,
        ST_GAP,
        ST_BOOT
`ifdef LCD_INIT_SEQ_EN
        , ST_INIT_WAIT
`endif
    } state_t;

    state_t     state;
    cnt_t       cnt;
    logic       cap_rs;
    logic [7:0] cap_data;
    logic       long_gap;

`ifdef LCD_INIT_SEQ_EN
    logic       init_act;
    logic [1:0] init_idx;

    assign long_gap = init_act || (!cap_rs && (cap_data == 8'h01 || cap_data == 8'h02));
`else
    assign long_gap = !cap_rs && (cap_data == 8'h01 || cap_data == 8'h02);
`endif

    assign wr_ready = (state == ST_IDLE);
    assign busy     = ~wr_ready;
    assign sf_e     = 1'b1;
    assign rw       = 1'b0;

    // Every state counts down from its load value and leaves when the count reaches one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            cnt      <= '0;
            e        <= 1'b0;
            rs       <= 1'b0;
            lcd_nib  <= 4'h0;
            cap_rs   <= 1'b0;
            cap_data <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
            init_act <= 1'b0;
            init_idx <= 2'd0;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
`ifdef LCD_INIT_SEQ_EN
                    state    <= ST_INIT_WAIT;
                    cnt      <= INIT_LD;
                    init_act <= 1'b1;
                    init_idx <= 2'd0;
`else
                    state <= ST_IDLE;
                    cnt   <= '0;
`endif
                end
`ifdef LCD_INIT_SEQ_EN
                ST_INIT_WAIT: begin
                    if (cnt == ONE) begin
                        state   <= ST_SETUP_LO;
                        cnt     <= SETUP_LD;
                        rs      <= 1'b0;
                        lcd_nib <= 4'h3;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
`endif
                ST_IDLE: begin
                    if (wr_valid) begin
                        state    <= ST_SETUP_HI;
                        cnt      <= SETUP_LD;
                        cap_rs   <= wr_rs;
                        cap_data <= wr_data;
                        rs       <= wr_rs;
                        lcd_nib  <= wr_data[7:4];
                    end
                end
                ST_SETUP_HI, ST_SETUP_LO: begin
                    if (cnt == ONE) begin
                        state <= (state == ST_SETUP_HI) ? ST_PULSE_HI : ST_PULSE_LO;
                        cnt   <= PULSE_LD;
                        e     <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_PULSE_HI, ST_PULSE_LO: begin
                    if (cnt == ONE) begin
                        state <= (state == ST_PULSE_HI) ? ST_HOLD_HI : ST_HOLD_LO;
                        cnt   <= HOLD_LD;
                        e     <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_HOLD_HI: begin
                    if (cnt == ONE) begin
                        state   <= ST_SETUP_LO;
                        cnt     <= SETUP_LD;
                        lcd_nib <= cap_data[3:0];
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_HOLD_LO: begin
                    if (cnt == ONE) begin
                        state <= ST_GAP;
                        cnt   <= long_gap ? LONG_LD : GAP_LD;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt == ONE) begin
`ifdef LCD_INIT_SEQ_EN
                        // Init nibbles reuse the low-nibble path; the fourth one is 0x2 (switch to 4-bit mode).
                        if (init_act && init_idx != 2'd3) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= ST_SETUP_LO;
                            cnt      <= SETUP_LD;
                            lcd_nib  <= (init_idx == 2'd2) ? 4'h2 : 4'h3;
                        end else begin
                            init_act <= 1'b0;
                            state    <= ST_IDLE;
                            cnt      <= '0;
                        end
`else
                        state <= ST_IDLE;
                        cnt   <= '0;
`endif
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                    cnt   <= '0;
                    e     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// tb_lcd_nibble_writer: randomized and directed checks of lcd_nibble_writer against a per-cycle waveform model.
// Honours LCD_INIT_SEQ_EN when the design is built with it.
module tb_lcd_nibble_writer;

    localparam int S  = 1;
    localparam int P  = 2;
    localparam int H  = 1;
    localparam int G  = 3;
    localparam int LG = 6;
    localparam int IW = 5;
    localparam int N  = S + P + H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, busy, e, sf_e, rs, rw;
    logic [3:0] lcd_nib;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lcd_nibble_writer #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
        .GAP_CYC(G), .LONG_GAP_CYC(LG), .INIT_WAIT_CYC(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .e(e), .sf_e(sf_e), .rs(rs), .rw(rw), .lcd_nib(lcd_nib)
    );

    function automatic int gap_of(input logic r, input logic [7:0] d);
        return (!r && (d == 8'h01 || d == 8'h02)) ? LG : G;
    endfunction

    // Expected {wr_ready,busy,e,rs,lcd_nib,sf_e,rw} n clocks after the transfer edge.
    function automatic logic [9:0] model(input logic r, input logic [7:0] d, input int n);
        int         ph;
        logic       ex_e;
        logic       ex_rdy;
        logic [3:0] nib;
        nib    = (n < N) ? d[7:4] : d[3:0];
        ph     = (n < N) ? n : n - N;
        ex_e   = (n < 2 * N) && (ph >= S) && (ph < S + P);
        ex_rdy = (n >= 2 * N + gap_of(r, d));
        return {ex_rdy, ~ex_rdy, ex_e, r, nib, 1'b1, 1'b0};
    endfunction

    function automatic logic [9:0] observed();
        return {wr_ready, busy, e, rs, lcd_nib, sf_e, rw};
    endfunction

    // Called at a negedge with the block idle; afterwards the held request is the next byte (or nothing).
    task automatic run_byte(input logic r, input logic [7:0] d, input logic nv,
                            input logic nr, input logic [7:0] nd, input string tag);
        int         len;
        logic [9:0] got;
        logic [9:0] want;
        len      = 2 * N + gap_of(r, d);
        wr_valid = 1'b1;
        wr_rs    = r;
        wr_data  = d;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s accept_ready: wr_ready=%b expected 1", tag, wr_ready);
        end
        @(posedge clk);
        for (int n = 0; n <= len; n++) begin
            @(negedge clk);
            if (n == 0) begin
                wr_valid = nv;
                wr_rs    = nr;
                wr_data  = nd;
            end
            got  = observed();
            want = model(r, d, n);
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL %s cycle%0d byte=%h rs=%b: {rdy,busy,e,rs,nib,sf_e,rw}=%b expected %b",
                         tag, n, d, r, got, want);
            end
        end
    endtask

    task automatic test_reset();
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'hC3;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (observed() !== 10'b01_0_0_0000_1_0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %b expected %b", observed(), 10'b01_0_0_0000_1_0);
        end
        wr_valid = 1'b0;
        rst_n    = 1'b1;
`ifdef LCD_INIT_SEQ_EN
        test_init();
`else
        @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || e !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_release: rdy=%b busy=%b e=%b expected 1 0 0", wr_ready, busy, e);
        end
`endif
    endtask

`ifdef LCD_INIT_SEQ_EN
    task automatic test_init();
        int         edges;
        logic       prev_e;
        logic       rs_bad;
        logic [3:0] nibs[$];
        logic [3:0] want_nib[4];
        want_nib = '{4'h3, 4'h3, 4'h3, 4'h2};
        edges  = 0;
        prev_e = 1'b0;
        rs_bad = 1'b0;
        while (wr_ready !== 1'b1 && edges < 500) begin
            @(negedge clk);
            edges++;
            if (e === 1'b1 && prev_e === 1'b0) begin
                nibs.push_back(lcd_nib);
                if (rs !== 1'b0) rs_bad = 1'b1;
            end
            prev_e = e;
        end
        n_cmp++;
        if (edges != 1 + IW + 4 * (N + LG)) begin
            n_fail++;
            $display("[TB] FAIL init_length: ready after %0d clocks expected %0d", edges, 1 + IW + 4 * (N + LG));
        end
        n_cmp++;
        if (nibs.size() != 4 || rs_bad) begin
            n_fail++;
            $display("[TB] FAIL init_pulses: %0d pulses rs_bad=%b expected 4 pulses rs=0", nibs.size(), rs_bad);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (nibs[i] !== want_nib[i]) begin
                    n_fail++;
                    $display("[TB] FAIL init_nib%0d: got %h expected %h", i, nibs[i], want_nib[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_single_data();
        run_byte(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, "single_41");
    endtask

    task automatic test_gap_select();
        run_byte(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, "clear_01");
        run_byte(1'b0, 8'h02, 1'b0, 1'b0, 8'h00, "home_02");
        run_byte(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, "data_01");
        run_byte(1'b0, 8'h03, 1'b0, 1'b0, 8'h00, "cmd_03");
    endtask

    task automatic test_back_to_back();
        run_byte(1'b1, 8'h30, 1'b1, 1'b1, 8'h31, "b2b_30");
        run_byte(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, "b2b_31");
    endtask

    task automatic test_busy_request();
        run_byte(1'b1, 8'h5A, 1'b1, 1'b0, 8'hA5, "busy_5A");
        run_byte(1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, "busy_A5");
    endtask

    task automatic test_random_stream();
        logic       r[20];
        logic [7:0] d[20];
        logic       idle_after[20];
        logic       nv;
        logic       nr;
        logic [7:0] nd;
        int         k;
        for (int i = 0; i < 20; i++) begin
            r[i] = 1'($urandom_range(0, 1));
            d[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                r[i] = 1'b0;
                d[i] = 8'($urandom_range(1, 2));
            end
            idle_after[i] = ($urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 20; i++) begin
            nv = (i < 19) && !idle_after[i];
            nr = 1'($urandom_range(0, 1));
            nd = 8'($urandom);
            if (nv) begin
                nr = r[i + 1];
                nd = d[i + 1];
            end
            run_byte(r[i], d[i], nv, nr, nd, "rand");
            if (!nv) begin
                k = $urandom_range(1, 4);
                repeat (k) begin
                    @(negedge clk);
                    n_cmp++;
                    if (wr_ready !== 1'b1 || e !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL rand_idle: rdy=%b e=%b expected 1 0", wr_ready, e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int pulses;
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h7E;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (S) @(negedge clk);
        n_cmp++;
        if (e !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pulse_before_reset: e=%b expected 1", e);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (observed() !== 10'b01_0_0_0000_1_0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %b expected %b", observed(), 10'b01_0_0_0000_1_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef LCD_INIT_SEQ_EN
        test_init();
`else
        pulses = 0;
        @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_after_abort: wr_ready=%b expected 1", wr_ready);
        end
        repeat (30) begin
            @(negedge clk);
            if (e === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("[TB] FAIL no_partial_completion: e high for %0d clocks expected 0", pulses);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_data();
        test_gap_select();
        test_back_to_back();
        test_busy_request();
        test_random_stream();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_writer.md
LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

Interface
REQ-001 Parameter SETUP_CYC, default 2, clocks that rs and the nibble are stable before e rises.
REQ-002 Parameter PULSE_CYC, default 12, clocks that e is high per nibble.
REQ-003 Parameter HOLD_CYC, default 2, clocks after e falls before the nibble may change.
REQ-004 Parameter GAP_CYC, default 2000, post-byte wait in clocks (40 us at 50 MHz).
REQ-005 Parameter LONG_GAP_CYC, default 82000, post-byte wait for the clear/home commands (1.64 ms).
REQ-006 Parameter INIT_WAIT_CYC, default 750000, power-up wait (15 ms); used only with the init feature.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 wr_valid  in  1  byte request from the upstream adder/display sequencer.
REQ-010 wr_rs  in  1  register select of the request (0 = command, 1 = data).
REQ-011 wr_data  in  8  byte to write.
REQ-012 wr_ready  out  1  block can accept a byte this cycle.
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 e, sf_e, rs, rw  out  1 each  LCD enable, StrataFlash disable (LCD access), register select, read/write.
REQ-015 lcd_nib  out  4  data nibble; bits 3..0 drive LCD pins d, c, b, a.

Function
REQ-016 Transfer: occurs on a clock edge where wr_valid and wr_ready are both high; wr_rs and wr_data are captured into internal registers.
REQ-017 Readiness: wr_ready is high only in IDLE and is combinationally independent of wr_valid.
REQ-018 Unaccepted requests: wr_valid while wr_ready is low captures nothing; the upstream holds the request until accepted.
REQ-019 States: IDLE, SETUP_HI, PULSE_HI, HOLD_HI, SETUP_LO, PULSE_LO, HOLD_LO, GAP.
- Each timed state lasts exactly its parameter count of clocks.
- The states advance in the listed order.
- GAP returns to IDLE.
REQ-020 Nibble timing: a transfer at edge T drives lcd_nib = wr_data[7:4] and rs = wr_rs from T+1; e is high for PULSE_CYC clocks starting at T+1+SETUP_CYC.
REQ-021 Low nibble: wr_data[3:0] is driven from the first SETUP_LO cycle, with identical e timing.
REQ-022 Gap length: GAP lasts LONG_GAP_CYC when the captured rs is 0 and the data is 0x01 or 0x02; otherwise it lasts GAP_CYC.
REQ-023 Latency: wr_ready reasserts exactly 2*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+gap clocks after the transfer edge.
REQ-024 Output rules: rw = 0 and sf_e = 1 at all times.
- e changes only in PULSE states.
- rs and lcd_nib never change while e = 1 or during HOLD states.
REQ-025 Registered outputs: e, rs and lcd_nib come from flops, with no combinational path from inputs.
REQ-026 Counter: a single down-counter, width $clog2 of the largest parameter plus 1; it reloads on every state entry, with no wrap-around.
REQ-027 Degenerate parameters: a parameter value of 0 is treated as 1.

Reset
REQ-028 While rst_n = 0, asynchronously:
- e = 0, rs = 0, rw = 0, sf_e = 1, lcd_nib = 0;
- wr_ready = 0, busy = 1, counter = 0.
REQ-029 Reset asserted mid-transfer drops e to 0 immediately and discards the byte; no partial completion follows.
REQ-030 Without LCD_INIT_SEQ_EN, the FSM enters IDLE on the first clock edge after rst_n rises, and wr_ready = 1 from that edge on.

Configuration
REQ-031 Macro LCD_INIT_SEQ_EN, when defined, compiles in the power-up sequence, run after reset release and before IDLE:
- wait INIT_WAIT_CYC;
- then send single nibbles 0x3, 0x3, 0x3, 0x2 with rs = 0, each using SETUP/PULSE/HOLD timing and followed by LONG_GAP_CYC.
REQ-032 During the init sequence, wr_ready = 0 and busy = 1; when the macro is undefined, the init states and INIT_WAIT_CYC logic are absent.

Verification (SETUP=1, PULSE=2, HOLD=1, GAP=3, LONG_GAP=6, INIT_WAIT=5)
REQ-033 Single data byte: rst_n release, then wr_rs = 1, wr_data = 0x41 accepted at T.
- lcd_nib = 4 for T+1..T+4, with e high at T+2..T+3.
- lcd_nib = 1 for T+5..T+8, with e high at T+6..T+7.
- wr_ready high again at T+12.
REQ-034 Clear command: wr_rs = 0, wr_data = 0x01 accepted at T -> exactly 2 e pulses, and wr_ready returns at T+15 (long gap).
REQ-035 Back-to-back bytes: wr_valid held high with 0x30, then 0x31 -> second transfer exactly at the wr_ready reassert edge; no e overlap; no dropped or duplicated byte.
REQ-036 Reset during PULSE_HI (e = 1): rst_n low -> e = 0 in the same cycle; after release, wr_ready = 1 and no further e pulses occur.
REQ-037 With LCD_INIT_SEQ_EN defined, after reset -> 4 e pulses with lcd_nib 3, 3, 3, 2 and rs = 0, wr_ready = 0 throughout, then wr_ready = 1.
REQ-038 Request while busy: a different wr_data presented while wr_ready = 0 -> the byte in flight is unchanged on lcd_nib.
